// File: rtl/cdb_writeback_arbiter_if.sv
// Purpose: result-source and CDB-port signal bundle for the writeback arbiter.
// Latency: none, wires only.
// Backpressure: src_ready per source towards the FUs, cdb_stall from the CDB consumers.
interface cdb_writeback_arbiter_if #(
  parameter int N_SRC = 5,
  parameter int N_CDB = 3,
  parameter int RES_W = 64
);
  logic [N_SRC-1:0]               src_valid;
  logic [N_SRC*RES_W-1:0]         src_data;
  logic [N_SRC-1:0]               src_ready;
  logic                           cdb_stall;
  logic [N_CDB-1:0]               cdb_valid;
  logic [N_CDB*RES_W-1:0]         cdb_data;
  logic [N_CDB*$clog2(N_SRC)-1:0] cdb_src;
  logic                           stall_out;

  // Arbiter side.
  modport slave (
    input  src_valid, src_data, cdb_stall,
    output src_ready, cdb_valid, cdb_data, cdb_src, stall_out
  );

  // Functional-unit / CDB-consumer side.
  modport master (
    output src_valid, src_data, cdb_stall,
    input  src_ready, cdb_valid, cdb_data, cdb_src, stall_out
  );
endinterface

// File: rtl/cdb_writeback_arbiter.sv
// Purpose: buffers FU results in 2-entry skid FIFOs and round-robin grants up to N_CDB per cycle onto the CDB.
// Latency: one cycle from enqueue into an empty FIFO to the registered CDB output; no bypass.
// Backpressure: src_ready drops when a FIFO is full; cdb_stall freezes grants and the CDB registers.
module cdb_writeback_arbiter #(
  parameter int N_SRC = 5,
  parameter int N_CDB = 3,
  parameter int RES_W = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  cdb_writeback_arbiter_if.slave bus
);
  localparam int SRC_W = $clog2(N_SRC);
  localparam int NG_W  = $clog2(N_CDB + 1);

  logic [RES_W-1:0] mem_q [N_SRC][2];
  logic [RES_W-1:0] mem_d [N_SRC][2];
  logic [1:0]       cnt_q [N_SRC];
  logic [1:0]       cnt_d [N_SRC];
  logic [N_SRC-1:0] wr_ptr_q, wr_ptr_d;
  logic [N_SRC-1:0] rd_ptr_q, rd_ptr_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_CDB-1:0] cdb_valid_q, cdb_valid_d;
  logic [RES_W-1:0] cdb_data_q [N_CDB];
  logic [RES_W-1:0] cdb_data_d [N_CDB];
  logic [SRC_W-1:0] cdb_src_q [N_CDB];
  logic [SRC_W-1:0] cdb_src_d [N_CDB];

  logic [N_SRC-1:0] src_rdy;
  logic [N_SRC-1:0] nonempty;
  logic [RES_W-1:0] src_dat [N_SRC];
  logic [N_SRC-1:0] enq;
  logic [N_SRC-1:0] deq;
  logic [N_CDB-1:0] gnt_vld;
  logic [SRC_W-1:0] gnt_idx [N_CDB];
  logic [SRC_W-1:0] last_idx;

  // Ready and occupancy come from the registered count only; a same-cycle dequeue does not reopen a full FIFO.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      src_rdy[i]  = (cnt_q[i] != 2'd2);
      nonempty[i] = (cnt_q[i] != 2'd0);
      src_dat[i]  = bus.src_data[i*RES_W +: RES_W];
    end
  end

  assign bus.src_ready = src_rdy;
  assign bus.stall_out = ~(&src_rdy);

  // Rotating scan from rr_ptr: the first N_CDB non-empty sources take ports 0.. in scan order.
  always_comb begin
    logic [SRC_W:0]  sum;
    logic [SRC_W-1:0] idx;
    logic [NG_W-1:0]  ng;
    sum      = '0;
    idx      = '0;
    ng       = '0;
    gnt_vld  = '0;
    last_idx = rr_ptr_q;
    for (int k = 0; k < N_CDB; k++) gnt_idx[k] = '0;
    for (int s = 0; s < N_SRC; s++) begin
      sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(s);
      if (sum >= (SRC_W+1)'(N_SRC)) sum = sum - (SRC_W+1)'(N_SRC);
      idx = sum[SRC_W-1:0];
      if (nonempty[idx] && (ng < NG_W'(N_CDB))) begin
        for (int k = 0; k < N_CDB; k++) begin
          if (NG_W'(k) == ng) begin
            gnt_vld[k] = 1'b1;
            gnt_idx[k] = idx;
          end
        end
        last_idx = idx;
        ng       = ng + NG_W'(1);
      end
    end
  end

  // Next state: flush wins over everything, stall freezes the CDB side but lets enqueues through.
  always_comb begin
    mem_d       = mem_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = cdb_valid_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    enq         = '0;
    deq         = '0;
    if (flush) begin
      for (int i = 0; i < N_SRC; i++) cnt_d[i] = 2'd0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cdb_valid_d = '0;
    end else begin
      enq = bus.src_valid & src_rdy;
      if (!bus.cdb_stall) begin
        cdb_valid_d = gnt_vld;
        for (int k = 0; k < N_CDB; k++) begin
          if (gnt_vld[k]) begin
            deq[gnt_idx[k]] = 1'b1;
            cdb_data_d[k]   = mem_q[gnt_idx[k]][rd_ptr_q[gnt_idx[k]]];
            cdb_src_d[k]    = gnt_idx[k];
          end
        end
        if (|gnt_vld) begin
          rr_ptr_d = (last_idx == SRC_W'(N_SRC - 1)) ? '0 : last_idx + SRC_W'(1);
        end
      end
      for (int i = 0; i < N_SRC; i++) begin
        if (enq[i]) begin
          mem_d[i][wr_ptr_q[i]] = src_dat[i];
          wr_ptr_d[i]           = ~wr_ptr_q[i];
        end
        if (deq[i]) rd_ptr_d[i] = ~rd_ptr_q[i];
        cnt_d[i] = cnt_q[i] + {1'b0, enq[i]} - {1'b0, deq[i]};
      end
    end
  end

  // State registers; reset empties every FIFO and clears the CDB outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SRC; i++) begin
        cnt_q[i]    <= 2'd0;
        mem_q[i][0] <= '0;
        mem_q[i][1] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rr_ptr_q    <= '0;
      cdb_valid_q <= '0;
      for (int k = 0; k < N_CDB; k++) begin
        cdb_data_q[k] <= '0;
        cdb_src_q[k]  <= '0;
      end
    end else begin
      mem_q       <= mem_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  for (genvar k = 0; k < N_CDB; k++) begin : g_out
    assign bus.cdb_data[k*RES_W +: RES_W] = cdb_data_q[k];
    assign bus.cdb_src[k*SRC_W +: SRC_W]  = cdb_src_q[k];
  end
  assign bus.cdb_valid = cdb_valid_q;

  // A source presenting a result into a full FIFO loses it; flag the protocol error.
  for (genvar i = 0; i < N_SRC; i++) begin : g_proto
    a_src_proto: assert property (@(posedge clk) disable iff (!rst_n) !(bus.src_valid[i] && !src_rdy[i]));
  end
endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
module tb_cdb_writeback_arbiter;
  localparam int N_SRC = 5;
  localparam int N_CDB = 3;
  localparam int RES_W = 64;
  localparam int SRC_W = 3;

  typedef struct {
    int          src;
    logic [63:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  cdb_writeback_arbiter_if #(.N_SRC(N_SRC), .N_CDB(N_CDB), .RES_W(RES_W)) bus ();

  cdb_writeback_arbiter #(.N_SRC(N_SRC), .N_CDB(N_CDB), .RES_W(RES_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        sb[$];
  logic [31:0] seq = 32'h100;
  logic [N_SRC-1:0] tick_gnt;
  int          gnt_cnt [N_SRC];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: offer results where ready, push them to the scoreboard, then check whatever the CDB broadcast.
  task automatic tick(input logic [N_SRC-1:0] want, input int mode);
    logic             upd;
    logic [63:0]      d;
    logic [SRC_W-1:0] s;
    int               hit;
    upd = !bus.cdb_stall && !flush;
    bus.src_valid = want & bus.src_ready;
    for (int i = 0; i < N_SRC; i++) begin
      if (mode == 1)      d = 64'hA5;
      else if (mode == 2) d = 64'(i);
      else                d = {32'(i), seq};
      bus.src_data[i*RES_W +: RES_W] = d;
      if (bus.src_valid[i] && !flush) begin
        sb.push_back('{src: i, dat: d});
        seq++;
      end
    end
    @(posedge clk);
    #1;
    bus.src_valid = '0;
    tick_gnt = '0;
    if (flush) begin
      sb.delete();
    end else if (upd) begin
      for (int k = 0; k < N_CDB; k++) begin
        if (bus.cdb_valid[k]) begin
          s   = bus.cdb_src[k*SRC_W +: SRC_W];
          hit = -1;
          foreach (sb[j]) if (hit < 0 && sb[j].src == int'(s)) hit = j;
          chk("sb_hit", 64'(hit >= 0), 64'd1);
          if (hit >= 0) begin
            chk("sb_data", bus.cdb_data[k*RES_W +: RES_W], sb[hit].dat);
            sb.delete(hit);
          end
          tick_gnt[s] = 1'b1;
          gnt_cnt[s]++;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_vld", 64'(bus.cdb_valid), 64'd0);
    chk("rst_rdy", 64'(bus.src_ready), 64'h1f);
    rst_n = 1'b1;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_x;
    logic [63:0] first_2;
    int          miss [N_SRC];
    int          max_miss;

    rst_n = 1'b0;
    flush = 1'b0;
    bus.cdb_stall = 1'b0;
    bus.src_valid = '0;
    bus.src_data  = '0;
    for (int i = 0; i < N_SRC; i++) gnt_cnt[i] = 0;

    // Reset and idle.
    #3;
    chk("reset_vld", 64'(bus.cdb_valid), 64'd0);
    chk("reset_rdy", 64'(bus.src_ready), 64'h1f);
    chk("reset_stall_out", 64'(bus.stall_out), 64'd0);
    chk("reset_dat", bus.cdb_data[63:0], 64'd0);
    chk("reset_src", 64'(bus.cdb_src), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick('0, 0);
      chk("idle_vld", 64'(bus.cdb_valid), 64'd0);
      chk("idle_rdy", 64'(bus.src_ready), 64'h1f);
      chk("idle_stall_out", 64'(bus.stall_out), 64'd0);
    end

    // Single result: visible one edge after the enqueue edge.
    tick(5'b00001, 1);
    chk("single_no_bypass", 64'(bus.cdb_valid), 64'd0);
    tick('0, 0);
    chk("single_vld", 64'(bus.cdb_valid), 64'b001);
    chk("single_dat", bus.cdb_data[63:0], 64'hA5);
    chk("single_src", 64'(bus.cdb_src[2:0]), 64'd0);

    // Oversubscription from rr_ptr=0.
    do_reset();
    tick(5'b11111, 2);
    tick('0, 0);
    chk("ovs1_vld", 64'(bus.cdb_valid), 64'b111);
    chk("ovs1_src0", 64'(bus.cdb_src[2:0]), 64'd0);
    chk("ovs1_src1", 64'(bus.cdb_src[5:3]), 64'd1);
    chk("ovs1_src2", 64'(bus.cdb_src[8:6]), 64'd2);
    tick('0, 0);
    chk("ovs2_vld", 64'(bus.cdb_valid), 64'b011);
    chk("ovs2_src0", 64'(bus.cdb_src[2:0]), 64'd3);
    chk("ovs2_src1", 64'(bus.cdb_src[5:3]), 64'd4);
    tick('0, 0);
    chk("ovs3_vld", 64'(bus.cdb_valid), 64'd0);

    // Fairness: all sources offering continuously for 10 broadcast cycles.
    tick(5'b11111, 0);
    for (int i = 0; i < N_SRC; i++) begin
      gnt_cnt[i] = 0;
      miss[i]    = 0;
    end
    max_miss = 0;
    for (int c = 0; c < 10; c++) begin
      tick(5'b11111, 0);
      for (int i = 0; i < N_SRC; i++) begin
        if (tick_gnt[i]) miss[i] = 0;
        else miss[i]++;
        if (miss[i] > max_miss) max_miss = miss[i];
      end
    end
    for (int i = 0; i < N_SRC; i++) chk("fair_cnt", 64'(gnt_cnt[i]), 64'd6);
    chk("fair_wait_gt2", 64'(max_miss > 2), 64'd0);
    for (int n = 0; n < 40 && sb.size() != 0; n++) tick('0, 0);
    chk("fair_drained", 64'(sb.size()), 64'd0);

    // Backpressure: CDB holds while source 2 fills its FIFO.
    exp_x = {32'd1, seq};
    tick(5'b00010, 0);
    first_2 = {32'd2, seq};
    tick('0, 0);
    chk("bp_pre_vld", 64'(bus.cdb_valid), 64'b001);
    chk("bp_pre_src", 64'(bus.cdb_src[2:0]), 64'd1);
    bus.cdb_stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(5'b00100, 0);
      chk("bp_hold_vld", 64'(bus.cdb_valid), 64'b001);
      chk("bp_hold_src", 64'(bus.cdb_src[2:0]), 64'd1);
      chk("bp_hold_dat", bus.cdb_data[63:0], exp_x);
      if (c == 1) begin
        chk("bp_rdy2", 64'(bus.src_ready[2]), 64'd0);
        chk("bp_stall_out", 64'(bus.stall_out), 64'd1);
      end
    end
    bus.cdb_stall = 1'b0;
    tick('0, 0);
    chk("bp_drain_src", 64'(bus.cdb_src[2:0]), 64'd2);
    chk("bp_drain_dat", bus.cdb_data[63:0], first_2);
    for (int n = 0; n < 40 && sb.size() != 0; n++) tick('0, 0);
    chk("bp_drained", 64'(sb.size()), 64'd0);

    // Flush with two results buffered in sources 0 and 3.
    bus.cdb_stall = 1'b1;
    tick(5'b01001, 0);
    tick(5'b01001, 0);
    chk("fl_pre_rdy", 64'(bus.src_ready), 64'b10110);
    flush = 1'b1;
    tick(5'b00010, 0);
    flush = 1'b0;
    chk("fl_vld", 64'(bus.cdb_valid), 64'd0);
    chk("fl_rdy", 64'(bus.src_ready), 64'h1f);
    chk("fl_stall_out", 64'(bus.stall_out), 64'd0);
    bus.cdb_stall = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick('0, 0);
      chk("fl_post_vld", 64'(bus.cdb_valid), 64'd0);
    end

    // Reset asserted mid-operation clears the CDB immediately.
    tick(5'b10000, 0);
    tick('0, 0);
    chk("mr_pre_vld", 64'(bus.cdb_valid), 64'b001);
    rst_n = 1'b0;
    #1;
    chk("mr_vld", 64'(bus.cdb_valid), 64'd0);
    chk("mr_dat", bus.cdb_data[63:0], 64'd0);
    rst_n = 1'b1;
    sb.delete();
    tick('0, 0);
    chk("mr_post_vld", 64'(bus.cdb_valid), 64'd0);

    chk("sb_final", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cdb_writeback_arbiter.md
Name: cdb_writeback_arbiter

Overview:
- Schedules functional-unit results onto the common data bus (CDB).
- Sits between the functional units' unified result outputs and the CDB consumers: reservation stations, ROB and completion buffer.
- More result sources exist than CDB ports. Each source gets a 2-entry skid FIFO, and a rotating round-robin arbiter grants up to N_CDB sources per cycle.

Parameters:
- N_SRC, 5, number of result sources (ALU slots first, then MulDiv slots).
- N_CDB, 3, number of CDB broadcast ports.
- RES_W, 64, width of one result payload (tag, value, flags, packed).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; synchronous clear of all buffered results.
- src_valid  in  N_SRC  result present on source i this cycle.
- src_data  in  N_SRC*RES_W  payload of source i, at bits [i*RES_W +: RES_W].
- src_ready  out  N_SRC  source i may present a result this cycle.
- cdb_stall  in  1  CDB consumers cannot accept; hold all outputs.
- cdb_valid  out  N_CDB  CDB port k carries a result.
- cdb_data  out  N_CDB*RES_W  payload of port k.
- cdb_src  out  N_CDB*$clog2(N_SRC)  source index driving port k.
- stall_out  out  1  high when any src_ready bit is 0; feeds the functional units' stall.

Behaviour:
- Reset (rst_n=0, async): all FIFOs empty, rr_ptr=0, cdb_valid=0, cdb_data=0, cdb_src=0. Combinationally this gives src_ready=all 1s and stall_out=0.
- Per-source FIFO:
  - Depth 2, with a registered count 0..2.
  - src_ready[i] = (count_i < 2), computed from the registered count only. It does not account for a same-cycle dequeue.
  - Enqueue when src_valid[i] && src_ready[i]. A src_valid that arrives while src_ready=0 is a source protocol error; the payload is dropped and an assertion fires.
  - Enqueue and dequeue in the same cycle are both performed, and the count is unchanged.
- Arbitration, evaluated each cycle with cdb_stall=0:
  - Scan the non-empty FIFOs starting at index rr_ptr, ascending modulo N_SRC.
  - Grant the first min(N_CDB, non-empty count) of them.
  - Grant j goes to CDB port j, in scan order.
- Output register:
  - Granted FIFO heads are dequeued and registered into cdb_data/cdb_src, with cdb_valid set for ports 0..grants-1.
  - Unused ports get cdb_valid=0; their data is don't-care (kept at its previous value).
  - Latency: a result enqueued at edge N (FIFO previously empty) appears on the CDB after edge N+1. No same-cycle bypass.
- rr_ptr update: (last granted index + 1) mod N_SRC. It is unchanged when there are zero grants or cdb_stall=1.
- cdb_stall=1:
  - No grants and no dequeues; cdb_valid/cdb_data/cdb_src hold.
  - Enqueues continue while src_ready allows.
- flush=1 (synchronous, highest priority over enqueue, dequeue and stall):
  - All counts go to 0 and cdb_valid goes to 0 at the next edge; rr_ptr is preserved.
  - Inputs presented in the flush cycle are discarded.
- FIFO wrap: separate 1-bit rd/wr pointers per FIFO; the count derives the full/empty state.
- Reset asserted mid-operation: immediate clear, same as the reset values above. Results in flight are lost.

Test Plan:
- Reset/idle: rst_n=0 then 1 with no src_valid → cdb_valid=000, src_ready=11111, stall_out=0 every cycle.
- Single result:
  - Stimulus: src_valid=00001 with data=0xA5 at edge 0.
  - Response: cdb_valid=001, cdb_data[0]=0xA5, cdb_src[0]=0 after edge 1.
- Oversubscription:
  - Stimulus: all 5 sources valid for one cycle with data=i, rr_ptr=0.
  - First cycle: ports carry src 0,1,2 and rr_ptr=3.
  - Next cycle: ports carry src 3,4, cdb_valid=011, rr_ptr=0.
- Round-robin fairness: all 5 sources continuously valid for 10 cycles → each source granted exactly 6 times, no source waits more than 2 consecutive grant cycles.
- Backpressure:
  - Stimulus: cdb_stall=1 for 4 cycles while source 2 drives valid every cycle.
  - Response: after 2 enqueues src_ready[2]=0 and stall_out=1, and cdb outputs hold.
  - On stall release: source 2 results drain in order.
- Flush: with 2 results buffered in each of sources 0,3, flush=1 for one cycle → cdb_valid=000 next cycle, all src_ready=1, no stale result is ever broadcast.
